// File: rtl/router_ingress_ctrl.sv
// router_ingress_ctrl
//   Ingress controller of the 1x3 router. Accepts byte-serial packets,
//   decodes the destination port from the header byte {len[7:2], addr[1:0]},
//   and writes header, payload and parity bytes into the selected FIFO.
//   Throttles the source with busy while the target FIFO is not yet drained
//   or full, and reports parity/length errors at packet end.
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   pkt_valid   high on header and payload bytes, low on the parity byte
//   data_in     packet byte from the source
//   fifo_full   full flags of FIFO0..2
//   fifo_empty  empty flags of FIFO0..2
//   soft_reset  per-port soft reset from the read-timeout logic
//   wr_enb      one-hot (or zero) write enable to FIFO0..2
//   lfd_state   high while the header byte is being written
//   dout        write data shared by all FIFOs
//   busy        source must hold data_in/pkt_valid while high
//   parity_done one-cycle pulse at packet end
//   err         parity or length error of the last packet
module router_ingress_ctrl #(
  parameter logic [1:0] ADDR_INVALID = 2'b11
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_reset,
  output logic [2:0] wr_enb,
  output logic       lfd_state,
  output logic [7:0] dout,
  output logic       busy,
  output logic       parity_done,
  output logic       err
);

  typedef enum logic [2:0] {
    DECODE,
    WAIT_EMPTY,
    LFD,
    LOAD_DATA,
    FULL_WAIT,
    LOAD_AFTER_FULL,
    CHECK
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] hdr_q, hdr_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_is_par_q, hold_is_par_d;
  logic [7:0] calc_par_q, calc_par_d;
  logic [7:0] rx_par_q, rx_par_d;
  logic [5:0] pay_cnt_q, pay_cnt_d;
  logic [1:0] addr_q, addr_d;
  logic       err_q, err_d;

  // Flags padded to four entries so any 2-bit address indexes in range.
  logic [3:0] full_ext, empty_ext, sr_ext;
  logic [2:0] port_sel;
  logic       full_sel;

  always_comb begin
    full_ext  = {1'b0, fifo_full};
    empty_ext = {1'b0, fifo_empty};
    sr_ext    = {1'b0, soft_reset};
    port_sel  = 3'b001 << addr_q;
    full_sel  = full_ext[addr_q];
  end

  always_comb begin
    state_d       = state_q;
    hdr_d         = hdr_q;
    hold_d        = hold_q;
    hold_is_par_d = hold_is_par_q;
    calc_par_d    = calc_par_q;
    rx_par_d      = rx_par_q;
    pay_cnt_d     = pay_cnt_q;
    addr_d        = addr_q;
    err_d         = err_q;
    busy          = 1'b0;
    wr_enb        = '0;
    lfd_state     = 1'b0;
    dout          = '0;
    parity_done   = 1'b0;

    unique case (state_q)
      DECODE: begin
        if (pkt_valid && (data_in[1:0] != ADDR_INVALID)) begin
          hdr_d      = data_in;
          addr_d     = data_in[1:0];
          calc_par_d = data_in;
          pay_cnt_d  = '0;
          err_d      = 1'b0;
          state_d    = empty_ext[data_in[1:0]] ? LFD : WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: begin
        busy = 1'b1;
        if (empty_ext[addr_q]) state_d = LFD;
      end
      LFD: begin
        busy = 1'b1;
        dout = hdr_q;
        // Write is additionally qualified by !full so a write never reaches a full FIFO.
        if (!full_sel) begin
          lfd_state = 1'b1;
          wr_enb    = port_sel;
          state_d   = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        dout = data_in;
        // busy is low here, so the presented byte is consumed whether or not
        // the FIFO can take it this cycle.
        if (pkt_valid) begin
          calc_par_d = calc_par_q ^ data_in;
          pay_cnt_d  = pay_cnt_q + 6'd1;
        end else begin
          rx_par_d = data_in;
        end
        if (!full_sel) begin
          wr_enb  = port_sel;
          state_d = pkt_valid ? LOAD_DATA : CHECK;
        end else begin
          hold_d        = data_in;
          hold_is_par_d = !pkt_valid;
          state_d       = FULL_WAIT;
        end
      end
      FULL_WAIT: begin
        busy = 1'b1;
        if (!full_sel) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        busy = 1'b1;
        dout = hold_q;
        if (!full_sel) begin
          wr_enb  = port_sel;
          state_d = hold_is_par_q ? CHECK : LOAD_DATA;
        end
      end
      CHECK: begin
        busy        = 1'b1;
        parity_done = 1'b1;
        err_d       = (calc_par_q != rx_par_q) || (pay_cnt_q != hdr_q[7:2]);
        state_d     = DECODE;
      end
      default: state_d = DECODE;
    endcase

    // Soft reset aborts the packet; err and parity_done are left untouched.
    if ((state_q != DECODE) && sr_ext[addr_q]) begin
      state_d   = DECODE;
      wr_enb    = '0;
      lfd_state = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= DECODE;
      hdr_q         <= '0;
      hold_q        <= '0;
      hold_is_par_q <= 1'b0;
      calc_par_q    <= '0;
      rx_par_q      <= '0;
      pay_cnt_q     <= '0;
      addr_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_q         <= hdr_d;
      hold_q        <= hold_d;
      hold_is_par_q <= hold_is_par_d;
      calc_par_q    <= calc_par_d;
      rx_par_q      <= rx_par_d;
      pay_cnt_q     <= pay_cnt_d;
      addr_q        <= addr_d;
      err_q         <= err_d;
    end
  end

  assign err = err_q;

endmodule
